jb_axi_lite_master: RTL and testbench

JB_AXI_LITE_MASTER -- requirements
Module: jb_axi_lite_master

---
 rtl/jb_axi_lite_master.sv | 234 +++++++++++++++++++++++
 tb/tb_jb_axi_lite_master.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jb_axi_lite_master.sv
// Single-outstanding AXI4-lite master. It turns one command into AXI beats and
// returns the response, or aborts the transaction when the slave stalls too long.
module jb_axi_lite_master #(
    parameter int unsigned AXI_ADDR_WIDTH = 13,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_timeout,
    output logic [AXI_ADDR_WIDTH-1:0]     m_awaddr,
    output logic [2:0]                    m_awprot,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [AXI_DATA_WIDTH-1:0]     m_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic [1:0]                    m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_araddr,
    output logic [2:0]                    m_arprot,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [AXI_DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rvalid,
    output logic                          m_rready
);
    localparam int unsigned STRB_W  = AXI_DATA_WIDTH / 8;
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]           wstrb_q, wstrb_d;
    logic                        cmd_ready_q, cmd_ready_d;
    logic                        awvalid_q, awvalid_d;
    logic                        wvalid_q, wvalid_d;
    logic                        arvalid_q, arvalid_d;
    logic                        bready_q, bready_d;
    logic                        rready_q, rready_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                  rsp_resp_q, rsp_resp_d;
    logic                        rsp_timeout_q, rsp_timeout_d;
    logic                        timeout_hit;
    logic                        aw_left;
    logic                        w_left;
    logic                        abort;

    // Fires on the last counted cycle so the valids stay up exactly TIMEOUT_CYCLES cycles.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));
    assign aw_left     = awvalid_q && !m_awready;
    assign w_left      = wvalid_q && !m_wready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        abort         = 1'b0;

        if ((state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    cnt_d       = '0;
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (m_awready) awvalid_d = 1'b0;
                if (m_wready)  wvalid_d  = 1'b0;
                if (!aw_left && !w_left) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_bvalid) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            RD_REQ: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            RD_RESP: begin
                if (m_rvalid) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_rresp;
                    rsp_rdata_d   = m_rdata;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A handshake on the expiry cycle never reaches here, so it wins over the abort.
        if (abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
            state_d       = RSP;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            cmd_ready_q   <= 1'b1;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;
    assign m_awaddr    = addr_q;
    assign m_awprot    = 3'b000;
    assign m_awvalid   = awvalid_q;
    assign m_wdata     = wdata_q;
    assign m_wstrb     = wstrb_q;
    assign m_wvalid    = wvalid_q;
    assign m_bready    = bready_q;
    assign m_araddr    = addr_q;
    assign m_arprot    = 3'b000;
    assign m_arvalid   = arvalid_q;
    assign m_rready    = rready_q;

endmodule

// File: tb/tb_jb_axi_lite_master.sv
// Bench for jb_axi_lite_master: a latency-programmable AXI4-lite slave with its own
// memory, command/response drivers, and a queue of expected responses.
module tb_jb_axi_lite_master;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [2:0]    m_awprot, m_arprot;
    logic          m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
    logic          m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic [1:0]    m_bresp = 2'b00, m_rresp = 2'b00;
    logic          m_bvalid = 1'b0, m_rvalid = 1'b0;
    logic [DW-1:0] m_rdata = '0;

    jb_axi_lite_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .srst(srst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail = 0;
    logic [34:0] exp_q[$];
    logic [DW-1:0] ref_mem[2048];

    // ---------------- slave model ----------------
    logic [DW-1:0] slave_mem[2048];
    int            aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
    logic [1:0]    s_bresp = 2'b00, s_rresp = 2'b00;
    logic          flush = 1'b1;
    int            aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int            aw_vc, w_vc, ar_vc;
    int            tot_aw = 0, tot_w = 0, tot_ar = 0, rule_err = 0;
    logic          aw_got, w_got, ar_got, b_done, r_done, b_fire, r_fire;
    logic          p_aw, p_w, p_ar;
    logic [AW-1:0] p_awaddr, p_araddr, aw_addr_s, ar_addr_s;
    logic [DW-1:0] p_wdata, w_data_s;
    logic [SW-1:0] p_wstrb, w_strb_s;

    // Runs on the falling edge: updates readies/valids and predicts which handshakes
    // the next rising edge will complete.
    initial begin
        forever begin
            @(negedge clk);
            if (flush) begin
                m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_done = 0; r_done = 0; b_fire = 0; r_fire = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_vc = 0; w_vc = 0; ar_vc = 0; p_aw = 0; p_w = 0; p_ar = 0;
                flush = 0;
            end
            if (p_aw && ((!m_awvalid && !rsp_timeout) || (m_awvalid && m_awaddr !== p_awaddr))) rule_err++;
            if (p_w && ((!m_wvalid && !rsp_timeout) || (m_wvalid && (m_wdata !== p_wdata || m_wstrb !== p_wstrb)))) rule_err++;
            if (p_ar && ((!m_arvalid && !rsp_timeout) || (m_arvalid && m_araddr !== p_araddr))) rule_err++;
            if (m_awprot !== 3'b000 || m_arprot !== 3'b000) rule_err++;

            if (m_awvalid === 1'b1) begin aw_vc++; m_awready = (aw_cnt >= aw_lat); aw_cnt++; end
            else m_awready = 0;
            if (m_awvalid === 1'b1 && m_awready) begin aw_got = 1; aw_addr_s = m_awaddr; tot_aw++; aw_cnt = 0; end
            if (m_wvalid === 1'b1) begin w_vc++; m_wready = (w_cnt >= w_lat); w_cnt++; end
            else m_wready = 0;
            if (m_wvalid === 1'b1 && m_wready) begin w_got = 1; w_data_s = m_wdata; w_strb_s = m_wstrb; tot_w++; w_cnt = 0; end
            if (m_arvalid === 1'b1) begin ar_vc++; m_arready = (ar_cnt >= ar_lat); ar_cnt++; end
            else m_arready = 0;
            if (m_arvalid === 1'b1 && m_arready) begin ar_got = 1; ar_addr_s = m_araddr; tot_ar++; ar_cnt = 0; end

            if (b_fire) begin m_bvalid = 0; b_fire = 0; b_done = 1; end
            if (aw_got && w_got && !b_done && !m_bvalid) begin
                if (b_cnt >= b_lat) begin
                    m_bvalid = 1; m_bresp = s_bresp;
                    for (int b = 0; b < SW; b++)
                        if (w_strb_s[b]) slave_mem[aw_addr_s[12:2]][8*b +: 8] = w_data_s[8*b +: 8];
                end else b_cnt++;
            end
            if (m_bvalid && m_bready === 1'b1) b_fire = 1;

            if (r_fire) begin m_rvalid = 0; r_fire = 0; r_done = 1; end
            if (ar_got && !r_done && !m_rvalid) begin
                if (r_cnt >= r_lat) begin
                    m_rvalid = 1; m_rdata = slave_mem[ar_addr_s[12:2]]; m_rresp = s_rresp;
                end else r_cnt++;
            end
            if (m_rvalid && m_rready === 1'b1) r_fire = 1;

            p_aw = (m_awvalid === 1'b1) && !m_awready; p_awaddr = m_awaddr;
            p_w  = (m_wvalid === 1'b1) && !m_wready;   p_wdata = m_wdata; p_wstrb = m_wstrb;
            p_ar = (m_arvalid === 1'b1) && !m_arready; p_araddr = m_araddr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        for (int b = 0; b < SW; b++)
            if (s[b]) ref_mem[a[12:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic do_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
        int   n = 0;
        logic rdy;
        logic ok = 0;
        flush = 1;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!ok && n < 100) begin
            rdy = (cmd_ready === 1'b1);
            @(posedge clk); #1;
            ok = rdy; n++;
        end
        cmd_valid = 0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cmd_accept: cmd_ready never seen in %0d cycles, required acceptance", n);
        end
    endtask

    // Waits for a response, holds rsp_ready low for 'hold' cycles, then accepts it.
    // 'bad' counts cycles that broke the response/command handshake rules.
    task automatic get_rsp(input int hold, output logic [DW-1:0] rd, output logic [1:0] rs,
                           output logic to, output int bad);
        int n = 0;
        bad = 0;
        rsp_ready = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin
            if (cmd_ready !== 1'b0) bad++;
            @(posedge clk); #1; n++;
        end
        rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_resp !== rs ||
                rsp_timeout !== to || cmd_ready !== 1'b0) bad++;
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) bad++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        srst = 1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_handshake: got %b, required 1000000",
                     {cmd_ready, rsp_valid, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready});
        end
        n_checks++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: rdata=%h resp=%b timeout=%b, required all 0", rsp_rdata, rsp_resp, rsp_timeout);
        end
        srst = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, m_awvalid, m_arvalid, m_awprot, m_arprot} !== 10'b1000000000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b, required 1000000000",
                     {cmd_ready, rsp_valid, m_awvalid, m_arvalid, m_awprot, m_arprot});
        end
    endtask

    task automatic test_write_basic();
        logic [DW-1:0] rd; logic [1:0] rs; logic to; int bad; logic [34:0] exp;
        int aw0 = tot_aw, w0 = tot_w;
        aw_lat = 0; w_lat = 2; b_lat = 1; s_bresp = 2'b00;
        exp_q.push_back({2'b00, 1'b0, 32'h0});
        ref_write(13'h010, 32'hDEADBEEF, 4'hF);
        do_cmd(1'b1, 13'h010, 32'hDEADBEEF, 4'hF);
        get_rsp(0, rd, rs, to, bad);
        exp = exp_q.pop_front();
        n_checks++;
        if ({rs, to, rd} !== exp) begin
            n_fail++; $display("FAIL write_rsp: got %h, required %h", {rs, to, rd}, exp);
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL write_handshake: %0d bad cycles, required 0", bad); end
        n_checks++;
        if (aw_addr_s !== 13'h010 || w_data_s !== 32'hDEADBEEF || w_strb_s !== 4'hF) begin
            n_fail++;
            $display("FAIL write_beat: addr=%h data=%h strb=%h, required 010 deadbeef f", aw_addr_s, w_data_s, w_strb_s);
        end
        n_checks++;
        if (aw_vc != 1 || w_vc != 3 || tot_aw - aw0 != 1 || tot_w - w0 != 1) begin
            n_fail++;
            $display("FAIL write_valid_cycles: aw=%0d w=%0d beats=%0d/%0d, required 1 3 1/1",
                     aw_vc, w_vc, tot_aw - aw0, tot_w - w0);
        end
    endtask

    task automatic test_read_basic();
        logic [DW-1:0] rd; logic [1:0] rs; logic to; int bad; logic [34:0] exp;
        slave_mem[11'h7FF] = 32'h12345678;
        ref_mem[11'h7FF]   = 32'h12345678;
        ar_lat = 2; r_lat = 1; s_rresp = 2'b00;
        exp_q.push_back({2'b00, 1'b0, ref_mem[11'h7FF]});
        do_cmd(1'b0, 13'h1FFC, 32'h0, 4'h0);
        get_rsp(2, rd, rs, to, bad);
        exp = exp_q.pop_front();
        n_checks++;
        if ({rs, to, rd} !== exp) begin
            n_fail++; $display("FAIL read_rsp: got %h, required %h", {rs, to, rd}, exp);
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL read_cmd_ready_low: %0d bad cycles, required 0", bad); end
        n_checks++;
        if (ar_vc != 3 || ar_addr_s !== 13'h1FFC || m_arvalid !== 1'b0 || m_rready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_ar: vc=%0d addr=%h arvalid=%b rready=%b, required 3 1ffc 0 0",
                     ar_vc, ar_addr_s, m_arvalid, m_rready);
        end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] rd; logic [1:0] rs; logic to; int bad; logic [34:0] exp;
        ar_lat = 1000;
        exp_q.push_back({2'b10, 1'b1, 32'h0});
        do_cmd(1'b0, 13'h0040, 32'h0, 4'h0);
        get_rsp(0, rd, rs, to, bad);
        exp = exp_q.pop_front();
        n_checks++;
        if ({rs, to, rd} !== exp) begin
            n_fail++; $display("FAIL timeout_rsp: got %h, required %h", {rs, to, rd}, exp);
        end
        n_checks++;
        if (ar_vc != TO || bad != 0 || m_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_arvalid: high %0d cycles bad=%0d arvalid=%b, required %0d 0 0", ar_vc, bad, m_arvalid, TO);
        end
        ar_lat = 0;
    endtask

    task automatic test_slverr_hold();
        logic [DW-1:0] rd; logic [1:0] rs; logic to; int bad; logic [34:0] exp;
        logic [DW-1:0] d = $urandom;
        aw_lat = 1; w_lat = 0; b_lat = 2; s_bresp = 2'b11;
        exp_q.push_back({2'b11, 1'b0, 32'h0});
        ref_write(13'h020, d, 4'h3);
        do_cmd(1'b1, 13'h020, d, 4'h3);
        get_rsp(5, rd, rs, to, bad);
        exp = exp_q.pop_front();
        n_checks++;
        if ({rs, to, rd} !== exp) begin
            n_fail++; $display("FAIL slverr_rsp: got %h, required %h", {rs, to, rd}, exp);
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL slverr_hold: %0d unstable cycles, required 0", bad); end
        s_bresp = 2'b00;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] rd; logic [1:0] rs; logic to; int bad; logic [34:0] exp;
        int n = 0;
        aw_lat = 0; w_lat = 0; b_lat = 1000;
        do_cmd(1'b1, 13'h100, 32'hCAFEF00D, 4'hF);
        // The slave still commits this write when it finally issues B.
        ref_write(13'h100, 32'hCAFEF00D, 4'hF);
        while (m_bready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (m_bready !== 1'b1) begin n_fail++; $display("FAIL reach_wr_resp: bready=%b, required 1", m_bready); end
        srst = 1;
        @(posedge clk); #1;
        srst = 0;
        n_checks++;
        if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid, cmd_ready, rsp_resp, rsp_timeout} !== 10'b0000001000) begin
            n_fail++;
            $display("FAIL reset_mid: got %b, required 0000001000",
                     {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid, cmd_ready, rsp_resp, rsp_timeout});
        end
        b_lat = 0;
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || m_bready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL late_bvalid: %0d cycles reacted, required 0", bad); end
        ar_lat = 1; r_lat = 0; s_rresp = 2'b00;
        exp_q.push_back({2'b00, 1'b0, ref_mem[11'h080]});
        do_cmd(1'b0, 13'h200, 32'h0, 4'h0);
        get_rsp(0, rd, rs, to, bad);
        exp = exp_q.pop_front();
        n_checks++;
        if ({rs, to, rd} !== exp || bad != 0) begin
            n_fail++; $display("FAIL read_after_reset: got %h bad=%0d, required %h bad=0", {rs, to, rd}, bad, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] rd; logic [1:0] rs; logic to; int bad; logic [34:0] exp;
        logic wr; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;
        int aw0 = tot_aw, w0 = tot_w, ar0 = tot_ar, err0 = rule_err, nw = 0, nr = 0;
        for (int i = 0; i < 100; i++) begin
            wr = 1'($urandom_range(0, 1));
            a = {11'($urandom_range(0, 2047)), 2'b00};
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); ar_lat = $urandom_range(0, 3);
            b_lat = $urandom_range(0, 3);  r_lat = $urandom_range(0, 3);
            s_bresp = 2'($urandom_range(0, 3)); s_rresp = 2'($urandom_range(0, 3));
            if (wr) begin
                exp_q.push_back({s_bresp, 1'b0, 32'h0});
                ref_write(a, d, s);
                nw++;
            end else begin
                exp_q.push_back({s_rresp, 1'b0, ref_mem[a[12:2]]});
                nr++;
            end
            do_cmd(wr, a, d, s);
            get_rsp($urandom_range(0, 2), rd, rs, to, bad);
            exp = exp_q.pop_front();
            n_checks++;
            if ({rs, to, rd} !== exp || bad != 0) begin
                n_fail++;
                $display("FAIL b2b_rsp[%0d] wr=%b addr=%h: got %h bad=%0d, required %h bad=0", i, wr, a, {rs, to, rd}, bad, exp);
            end
        end
        n_checks++;
        if (rule_err != err0) begin n_fail++; $display("FAIL axi_stability: %0d violations, required 0", rule_err - err0); end
        n_checks++;
        if (tot_aw - aw0 != nw || tot_w - w0 != nw || tot_ar - ar0 != nr) begin
            n_fail++;
            $display("FAIL beat_count: aw=%0d w=%0d ar=%0d, required %0d %0d %0d",
                     tot_aw - aw0, tot_w - w0, tot_ar - ar0, nw, nw, nr);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            slave_mem[i] = 32'h5A000000 ^ (i * 32'h01000193);
            ref_mem[i]   = 32'h5A000000 ^ (i * 32'h01000193);
        end
        test_reset();
        test_write_basic();
        test_read_basic();
        test_timeout();
        test_slverr_hold();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
